// File: rtl/bft_pkg.sv
// Shared BFT packet layout, credit constants and packet pack/unpack helpers.
package bft_pkg;

    localparam int PKT_W     = 49;
    localparam int PAY_W     = 32;
    localparam int LEAF_W    = 4;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;
    localparam int RET_W     = 8;

    localparam int VALID_BIT = 48;
    localparam int LEAF_MSB  = 47;
    localparam int LEAF_LSB  = 44;
    localparam int PORT_MSB  = 43;
    localparam int PORT_LSB  = 40;
    localparam int SEQ_MSB   = 39;
    localparam int SEQ_LSB   = 33;
    localparam int CTRL_BIT  = 32;

    // One extra bit so the full-buffer value 2^ADDR_W is representable.
    localparam int CREDIT_BITS = ADDR_W + 1;
    localparam int SUM_W       = CREDIT_BITS + 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(2 ** ADDR_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } inj_state_t;

    typedef struct packed {
        logic              valid;
        logic [LEAF_W-1:0] leaf;
        logic [PORT_W-1:0] port;
        logic [ADDR_W-1:0] seq;
        logic              ctrl;
        logic [PAY_W-1:0]  payload;
    } bft_pkt_t;

    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [LEAF_W-1:0] leaf,
        input logic [PORT_W-1:0] port,
        input logic [ADDR_W-1:0] seq,
        input logic              ctrl,
        input logic [PAY_W-1:0]  payload
    );
        logic [PKT_W-1:0] raw;
        raw                    = '0;
        raw[VALID_BIT]         = 1'b1;
        raw[LEAF_MSB:LEAF_LSB] = leaf;
        raw[PORT_MSB:PORT_LSB] = port;
        raw[SEQ_MSB:SEQ_LSB]   = seq;
        raw[CTRL_BIT]          = ctrl;
        raw[PAY_W-1:0]         = payload;
        return raw;
    endfunction

    function automatic bft_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
        bft_pkt_t pkt;
        pkt.valid   = raw[VALID_BIT];
        pkt.leaf    = raw[LEAF_MSB:LEAF_LSB];
        pkt.port    = raw[PORT_MSB:PORT_LSB];
        pkt.seq     = raw[SEQ_MSB:SEQ_LSB];
        pkt.ctrl    = raw[CTRL_BIT];
        pkt.payload = raw[PAY_W-1:0];
        return pkt;
    endfunction

endpackage

// File: rtl/bft_credit_counter.sv
// Saturating credit counter with sticky overflow flag and registered stream-ready.
module bft_credit_counter
    import bft_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_send,
    input  logic                   i_ret_vld,
    input  logic [RET_W-1:0]       i_ret,
    input  logic                   i_run_next,
    output logic [CREDIT_BITS-1:0] o_credits,
    output logic                   o_err,
    output logic                   o_ready
);

    logic [CREDIT_BITS-1:0] r_credits;
    logic                   r_err;
    logic                   r_ready;
    logic [RET_W-1:0]       w_ret;
    logic [SUM_W-1:0]       w_sum;
    logic                   w_ovf;
    logic [CREDIT_BITS-1:0] w_next;

    // A send is only possible while credits are non-zero, so the sum never goes negative.
    always_comb begin
        w_ret  = i_ret_vld ? i_ret : '0;
        w_sum  = SUM_W'(r_credits) + SUM_W'(w_ret) - SUM_W'(i_send);
        w_ovf  = (w_sum > SUM_W'(CREDIT_MAX));
        w_next = w_ovf ? CREDIT_MAX : w_sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credits <= CREDIT_MAX;
            r_err     <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_credits <= w_next;
            r_err     <= r_err | w_ovf;
            r_ready   <= i_run_next && (w_next != '0);
        end
    end

    assign o_credits = r_credits;
    assign o_err     = r_err;
    assign o_ready   = r_ready;

endmodule

// File: rtl/bft_stream_injector.sv
// AXI-stream to BFT packet injector for a single destination leaf/port, credit throttled.
module bft_stream_injector
    import bft_pkg::*;
#(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 4,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int SELF_LEAF     = 0,
    parameter int SELF_PORT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ap_start,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [PACKET_BITS-1:0]   din_bft2injector,
    output logic [PACKET_BITS-1:0]   dout_injector2bft,
    output logic [NUM_ADDR_BITS:0]   credits,
    output logic                     credit_err
);

    inj_state_t               r_state;
    inj_state_t               w_state_next;
    logic [NUM_LEAF_BITS-1:0] r_leaf;
    logic [NUM_PORT_BITS-1:0] r_port;
    logic [NUM_ADDR_BITS-1:0] r_seq;
    logic [PACKET_BITS-1:0]   r_dout;
    logic                     w_run_next;
    logic                     w_latch;
    logic                     w_send;
    logic                     w_upd;
    bft_pkt_t                 w_rx;
    logic                     w_unused_rx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (ap_start)  w_state_next = ST_RUN;
            ST_RUN:  if (!ap_start) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run_next = (w_state_next == ST_RUN);
        w_latch    = (r_state == ST_IDLE) && ap_start;
    end

    // Only control packets addressed to this injector's own leaf/port carry credits.
    assign w_rx        = unpack_pkt(din_bft2injector);
    assign w_upd       = w_rx.valid && w_rx.ctrl &&
                         (w_rx.leaf == NUM_LEAF_BITS'(SELF_LEAF)) &&
                         (w_rx.port == NUM_PORT_BITS'(SELF_PORT));
    assign w_unused_rx = ^{w_rx.seq, w_rx.payload[PAY_W-1:RET_W]};
    assign w_send      = s_tvalid && s_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leaf <= '0;
            r_port <= '0;
            r_seq  <= '0;
            r_dout <= '0;
        end else begin
            if (w_latch) begin
                r_leaf <= dest_leaf;
                r_port <= dest_port;
            end
            if (w_send) begin
                r_seq <= r_seq + 1'b1;
            end
            r_dout <= w_send ? pack_pkt(r_leaf, r_port, r_seq, 1'b0, s_tdata) : '0;
        end
    end

    bft_credit_counter u_credit (
        .clk        (clk),
        .reset      (reset),
        .i_send     (w_send),
        .i_ret_vld  (w_upd),
        .i_ret      (w_rx.payload[RET_W-1:0]),
        .i_run_next (w_run_next),
        .o_credits  (credits),
        .o_err      (credit_err),
        .o_ready    (s_tready)
    );

    assign dout_injector2bft = r_dout;

endmodule
